seq_alu: RTL

Parametrised, registered ALU for the tiny CPU datapath. It is the successor to the 8-bit combinational ALU and keeps the same opcode map and status layout. It adds SUB, ADC, and rotate-through-carry. It also adds multi-cycle barrel-free shifts by N and a shift-add multiply behind a valid/ready handshake. The block sits between the register file read ports and the writeback/flag register. The sequencer must honour `ready_out`.

---
 rtl/seq_alu.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// ============================================================================
//  Module   : seq_alu
//  Brief    : Registered ALU with single-cycle ops plus multi-cycle shift-by-N
//             and shift-add multiply behind a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [3:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       status_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] result_out,
    output logic [3:0]       status_out
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_busy = 1'b1;

    localparam logic [3:0] c_op_shr  = 4'h0;
    localparam logic [3:0] c_op_shl  = 4'h1;
    localparam logic [3:0] c_op_ror  = 4'h2;
    localparam logic [3:0] c_op_rol  = 4'h3;
    localparam logic [3:0] c_op_inc  = 4'h4;
    localparam logic [3:0] c_op_dec  = 4'h5;
    localparam logic [3:0] c_op_add  = 4'h6;
    localparam logic [3:0] c_op_sub  = 4'h7;
    localparam logic [3:0] c_op_not  = 4'h8;
    localparam logic [3:0] c_op_and  = 4'h9;
    localparam logic [3:0] c_op_or   = 4'hA;
    localparam logic [3:0] c_op_mov  = 4'hB;
    localparam logic [3:0] c_op_shrn = 4'hC;
    localparam logic [3:0] c_op_shln = 4'hD;
    localparam logic [3:0] c_op_mul  = 4'hE;
    localparam logic [3:0] c_op_adc  = 4'hF;

    localparam logic [1:0] c_k_shrn = 2'd0;
    localparam logic [1:0] c_k_shln = 2'd1;
    localparam logic [1:0] c_k_mul  = 2'd2;

    logic [0:0]           r_state;
    logic [1:0]           r_kind;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_shreg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_vin;
    logic [WIDTH-1:0]     r_result;
    logic [3:0]           r_status;
    logic                 r_valid;

    logic                 w_cin;
    logic                 w_vin;
    logic [WIDTH-1:0]     w_bop;
    logic                 w_ci;
    logic [WIDTH:0]       w_sum;
    logic                 w_arith_v;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;
    logic [3:0]           w_status_single;
    logic [c_cnt_w-1:0]   w_shift_n;
    logic                 w_is_multi;
    logic [WIDTH-1:0]     w_sh_next;
    logic                 w_sh_cout;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]     w_fin_res;
    logic                 w_fin_c;
    logic                 w_unused;

    assign w_cin     = status_in[3];
    assign w_vin     = status_in[1];
    assign w_unused  = ^{status_in[2], status_in[0]};
    assign ready_out = (r_state == c_st_idle);

    // Every add-type op is a + operand + carry-in; SUB uses ~b with carry-in 1.
    always_comb begin
        w_bop = '0;
        w_ci  = 1'b0;
        case (op_in)
            c_op_inc: w_ci = 1'b1;
            c_op_dec: w_bop = '1;
            c_op_add: w_bop = b_in;
            c_op_adc: begin w_bop = b_in;  w_ci = w_cin; end
            c_op_sub: begin w_bop = ~b_in; w_ci = 1'b1;  end
            default:  ;
        endcase
        w_sum     = {1'b0, a_in} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_ci};
        w_arith_v = (a_in[WIDTH-1] == w_bop[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != a_in[WIDTH-1]);
    end

    always_comb begin
        w_res = a_in;
        w_c   = w_cin;
        w_v   = w_vin;
        case (op_in)
            c_op_shr: begin w_res = a_in >> 1; w_c = a_in[0]; end
            c_op_shl: begin w_res = a_in << 1; w_c = a_in[WIDTH-1]; end
            c_op_ror: begin w_res = {w_cin, a_in[WIDTH-1:1]}; w_c = a_in[0]; end
            c_op_rol: begin w_res = {a_in[WIDTH-2:0], w_cin}; w_c = a_in[WIDTH-1]; end
            c_op_inc, c_op_dec, c_op_add, c_op_sub, c_op_adc: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_arith_v;
            end
            c_op_not: w_res = ~a_in;
            c_op_and: w_res = a_in & b_in;
            c_op_or:  w_res = a_in | b_in;
            c_op_mov: w_res = a_in;
            default:  w_res = a_in;
        endcase
        w_status_single = {w_c, w_res[WIDTH-1], w_v, ~|w_res};
    end

    always_comb begin
        if (b_in >= WIDTH'(WIDTH)) begin
            w_shift_n = c_cnt_w'(WIDTH);
        end else begin
            w_shift_n = b_in[c_cnt_w-1:0];
        end
        w_is_multi = (op_in == c_op_mul) ||
                     (((op_in == c_op_shrn) || (op_in == c_op_shln)) &&
                      (w_shift_n != '0));
    end

    // One iteration of the active multi-cycle op, applied at every BUSY edge.
    always_comb begin
        if (r_kind == c_k_shln) begin
            w_sh_next = r_shreg << 1;
            w_sh_cout = r_shreg[WIDTH-1];
        end else begin
            w_sh_next = r_shreg >> 1;
            w_sh_cout = r_shreg[0];
        end
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        if (r_kind == c_k_mul) begin
            w_fin_res = w_acc_next[WIDTH-1:0];
            w_fin_c   = |w_acc_next[2*WIDTH-1:WIDTH];
        end else begin
            w_fin_res = w_sh_next;
            w_fin_c   = w_sh_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_kind   <= c_k_shrn;
            r_cnt    <= '0;
            r_shreg  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_vin    <= 1'b0;
            r_result <= '0;
            r_status <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (valid_in) begin
                        r_vin <= w_vin;
                        if (w_is_multi) begin
                            r_state  <= c_st_busy;
                            r_shreg  <= a_in;
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, a_in};
                            r_mplier <= b_in;
                            if (op_in == c_op_mul) begin
                                r_kind <= c_k_mul;
                                r_cnt  <= c_cnt_w'(WIDTH);
                            end else begin
                                r_kind <= (op_in == c_op_shln) ? c_k_shln : c_k_shrn;
                                r_cnt  <= w_shift_n;
                            end
                        end else begin
                            r_result <= w_res;
                            r_status <= w_status_single;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                c_st_busy: begin
                    r_cnt    <= r_cnt - c_cnt_w'(1);
                    r_shreg  <= w_sh_next;
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state  <= c_st_idle;
                        r_result <= w_fin_res;
                        r_status <= {w_fin_c, w_fin_res[WIDTH-1], r_vin, ~|w_fin_res};
                        r_valid  <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign valid_out  = r_valid;
    assign result_out = r_result;
    assign status_out = r_status;

endmodule

`default_nettype wire
